digit_serial_add_sub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands one DIGIT-bit slice per clock, LSB slice first.
//  A single DIGIT-wide full-adder chain is reused every cycle, with the carry held in a flip-flop between slices.
//  It trades latency for area in the arithmetic library.

---
 rtl/digit_serial_add_sub.sv | 152 +++++++++++++++
 tb/tb_digit_serial_add_sub.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_sub.sv
// digit_serial_add_sub
// Multi-cycle adder/subtractor. One DIGIT-wide adder is reused once per clock,
// LSB slice first. The carry between slices is held in a flop. Control uses a
// start/busy/done handshake with the states IDLE -> RUN -> DONE.
module digit_serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             ovf_out
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    // Refuse to elaborate when the operand cannot be split into whole slices
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_add_sub: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    // Operand B is stored already conditioned (B or ~B), so the adder never sees sub
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_slice;
    int               shamt;
    logic [DIGIT-1:0] a_slice;
    logic [DIGIT-1:0] b_slice;
    logic [DIGIT:0]   slice_full;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_carry;
    logic             slice_ovf;
    logic [WIDTH-1:0] slice_mask;
    logic [WIDTH-1:0] slice_ins;
    logic [WIDTH-1:0] sum_next;

    assign accept     = start_in && (state == IDLE || state == DONE);
    assign last_slice = (cnt == LAST);

    // State register; reset takes priority over everything, including a start
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start in DONE chains straight into another run
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start_in) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared slice adder: pick slice cnt of both operands and merge the result back in place
    always_comb begin
        shamt       = int'(cnt) * DIGIT;
        a_slice     = DIGIT'(a_reg >> shamt);
        b_slice     = DIGIT'(b_reg >> shamt);
        slice_full  = {1'b0, a_slice} + {1'b0, b_slice} + (DIGIT + 1)'(carry_reg);
        slice_sum   = slice_full[DIGIT-1:0];
        slice_carry = slice_full[DIGIT];
        slice_ovf   = (a_slice[DIGIT-1] == b_slice[DIGIT-1]) &&
                      (slice_sum[DIGIT-1] != a_slice[DIGIT-1]);
        slice_mask  = '0;
        slice_mask[DIGIT-1:0] = '1;
        slice_mask  = slice_mask << shamt;
        slice_ins   = '0;
        slice_ins[DIGIT-1:0] = slice_sum;
        slice_ins   = slice_ins << shamt;
        sum_next    = (sum_reg & ~slice_mask) | slice_ins;
    end

    // Datapath: latch operands and seed the carry at start, then consume one slice per RUN cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            a_reg     <= a_in;
            b_reg     <= sub_in ? ~b_in : b_in;
            carry_reg <= c_in ^ sub_in;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt       <= '0;
        end else if (state == RUN) begin
            sum_reg   <= sum_next;
            carry_reg <= slice_carry;
            cnt       <= cnt + CNT_W'(1);
            if (last_slice) begin
                ovf_reg <= slice_ovf;
            end
        end
    end

    assign busy_out  = (state == RUN);
    assign done_out  = (state == DONE);
    assign sum_out   = sum_reg;
    assign carry_out = carry_reg;
    assign ovf_out   = ovf_reg;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// tb_digit_serial_add_sub
// Drives three instances (DIGIT = 4, 16, 1 with WIDTH = 16) in parallel. Each
// accepted start pushes the reference result into a per-instance queue. A
// monitor pops and compares on every done pulse.
module tb_digit_serial_add_sub;

    logic clk = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   finished = 0;

    // Free-running clock shared by all instances
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (instance %0d): got %0h, want %0h", name, inst, act, exp);
        end
    endtask

    // Reference result {carry, ovf, sum} from plain integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s);
        int   r;
        int   sr;
        logic cy;
        if (!s) begin
            r  = int'(a) + int'(b) + int'(c);
            sr = int'(signed'(a)) + int'(signed'(b)) + int'(c);
            cy = (r > 65535);
        end else begin
            r  = int'(a) - int'(b) - int'(c);
            sr = int'(signed'(a)) - int'(signed'(b)) - int'(c);
            cy = (r >= 0);
        end
        return {cy, (sr > 32767 || sr < -32768), r[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int D      = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
        localparam int ND     = 16 / D;
        localparam int PULSE  = (ND >= 2) ? 2 : 1;
        localparam int RST_AT = (ND >= 3) ? 3 : ND;

        logic        rst;
        logic        start;
        logic        sub;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic        busy;
        logic        done;
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        logic [17:0] exp_q[$];

        digit_serial_add_sub #(.WIDTH(16), .DIGIT(D)) u_dut (
            .clk_in   (clk),
            .rst_in   (rst),
            .start_in (start),
            .sub_in   (sub),
            .a_in     (a),
            .b_in     (b),
            .c_in     (cin),
            .busy_out (busy),
            .done_out (done),
            .sum_out  (sum),
            .carry_out(carry),
            .ovf_out  (ovf)
        );

        task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
            a     = ta;
            b     = tb_;
            cin   = tc;
            sub   = ts;
            start = 1'b1;
            exp_q.push_back(model(ta, tb_, tc, ts));
        endtask

        task automatic scramble();
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
        endtask

        // One operation from the accepting edge to the done cycle, checking busy/done every cycle.
        // A nonzero pulse raises start in that RUN cycle with fresh operands, which must be ignored.
        task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts, input int pulse);
            applyStimulus(ta, tb_, tc, ts);
            for (int k = 1; k <= ND + 1; k++) begin
                @(posedge clk);
                #1;
                scramble();
                start = (k == pulse);
                @(negedge clk);
                check("busy", g, 32'(busy), 32'(k <= ND));
                check("done", g, 32'(done), 32'(k == ND + 1));
            end
        endtask

        // Start an operation, then reset it mid-run: outputs clear and no done may follow
        task automatic op_reset(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
            applyStimulus(ta, tb_, tc, ts);
            for (int k = 1; k <= RST_AT; k++) begin
                @(posedge clk);
                #1;
                scramble();
                start = 1'b0;
                @(negedge clk);
                check("busy_before_reset", g, 32'(busy), 32'(1));
            end
            rst = 1'b1;
            void'(exp_q.pop_back());
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("reset_busy", g, 32'(busy), 32'(0));
            check("reset_done", g, 32'(done), 32'(0));
            check("reset_sum", g, 32'(sum), 32'(0));
            check("reset_carry", g, 32'(carry), 32'(0));
            check("reset_ovf", g, 32'(ovf), 32'(0));
            repeat (ND + 2) begin
                @(negedge clk);
                check("no_done_after_reset", g, 32'(done), 32'(0));
            end
        endtask

        // Monitor: every done pulse must match the oldest outstanding expectation
        always @(negedge clk) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done (instance %0d): got done=1, want no result pending", g);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("sum", g, 32'(sum), 32'(e[15:0]));
                    check("carry", g, 32'(carry), 32'(e[17]));
                    check("ovf", g, 32'(ovf), 32'(e[16]));
                end
            end
        end

        // Stimulus sequence: reset, directed vectors, ignored start, mid-run reset, random regression
        initial begin
            rst   = 1'b1;
            start = 1'b1;
            a     = 16'h1111;
            b     = 16'h2222;
            cin   = 1'b1;
            sub   = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("reset_wins_busy", g, 32'(busy), 32'(0));
            check("reset_wins_done", g, 32'(done), 32'(0));
            check("reset_sum0", g, 32'(sum), 32'(0));
            check("reset_carry0", g, 32'(carry), 32'(0));
            check("reset_ovf0", g, 32'(ovf), 32'(0));
            rst   = 1'b0;
            start = 1'b0;
            @(posedge clk);
            #1;
            op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
            op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
            op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
            @(posedge clk);
            #1;
            op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
            op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
            op(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
            op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
            @(posedge clk);
            #1;
            op(16'h0F0F, 16'h7070, 1'b0, 1'b0, PULSE);
            @(posedge clk);
            #1;
            op_reset(16'hAAAA, 16'h5555, 1'b1, 1'b0);
            op(16'h1357, 16'h2468, 1'b0, 1'b0, 0);
            for (int n = 0; n < 1000; n++) begin
                int p;
                if ($urandom_range(1, 0) == 1) begin
                    @(posedge clk);
                    #1;
                end
                p = ($urandom_range(3, 0) == 0) ? int'($urandom_range(ND, 1)) : 0;
                op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), p);
            end
            @(posedge clk);
            #1;
            check("queue_drained", g, 32'(exp_q.size()), 32'(0));
            finished++;
        end
    end

    // Wait for all instances with a cycle budget, then report
    initial begin
        for (int i = 0; i < 40000 && finished < 3; i++) begin
            @(posedge clk);
        end
        if (finished < 3) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout: got %0d instances finished, want 3", finished);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
